// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default address width and Gray/binary pointer conversions,
// used by both the read-side and write-side pointer blocks.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;

  // Both helpers work on 32-bit words; callers zero-extend and cast back to pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/r_empty_ctrl_if.sv
// Consumer-facing read port of the FIFO empty controller.
interface r_empty_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  r_inc;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_empty;
  logic                  r_almost_empty;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_underflow;

  modport master (
    output r_inc,
    input  r_addr, r_empty, r_almost_empty, r_count, r_underflow
  );

  modport slave (
    input  r_inc,
    output r_addr, r_empty, r_almost_empty, r_count, r_underflow
  );

endinterface

// File: rtl/r_ptr_sync.sv
// Two-flop synchronizer bringing the Gray write pointer into the read clock domain.
module r_ptr_sync #(
  parameter int WIDTH = 4
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic [WIDTH-1:0] async_ptr,
  output logic [WIDTH-1:0] sync_ptr
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = async_ptr;
    sync_d = meta_q;
  end

  // NOTE: reset is sampled on the clock edge here, so it belongs inside the clocked
  // block and never in the sensitivity list.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_ptr = sync_q;

endmodule

// File: rtl/r_empty_ctrl.sv
// Read-side pointer and flag logic of an asynchronous FIFO: read address, Gray read
// pointer, and conservative empty / almost-empty / occupancy flags.
module r_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AE_THRESH  = 1
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic [ADDR_WIDTH:0] unsync_w_ptr,
  output logic [ADDR_WIDTH:0] gr_r_ptr,
  r_empty_ctrl_if.slave       rd_if
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t AE_LIMIT = PTR_W'(AE_THRESH);

  ptr_t sync_gr_w_ptr;
  ptr_t w_bin;
  ptr_t r_bin_q, r_bin_d;
  ptr_t r_gray_q, r_gray_d;
  ptr_t r_count_q, r_count_d;
  logic r_empty_q, r_empty_d;
  logic r_ae_q, r_ae_d;
  logic r_underflow_q, r_underflow_d;
  logic rd_ok;

  r_ptr_sync #(.WIDTH(PTR_W)) u_w_ptr_sync (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .async_ptr (unsync_w_ptr),
    .sync_ptr  (sync_gr_w_ptr)
  );

  // Flags compare against the post-read pointer, so a read in this cycle is already
  // reflected when the flags register; the stale synchronized write pointer can
  // only understate occupancy.
  always_comb begin
    rd_ok         = rd_if.r_inc & ~r_empty_q;
    r_bin_d       = r_bin_q + PTR_W'(rd_ok);
    r_gray_d      = PTR_W'(bin2gray(32'(r_bin_d)));
    w_bin         = PTR_W'(gray2bin(32'(sync_gr_w_ptr)));
    r_empty_d     = (r_gray_d == sync_gr_w_ptr);
    r_count_d     = w_bin - r_bin_d;
    r_ae_d        = (r_count_d <= AE_LIMIT);
    r_underflow_d = rd_if.r_inc & r_empty_q;
  end

  // NOTE: every state register updates with <= so all of them sample the same
  // pre-edge values, regardless of statement order.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_bin_q       <= '0;
      r_gray_q      <= '0;
      r_empty_q     <= 1'b1;
      r_ae_q        <= 1'b1;
      r_count_q     <= '0;
      r_underflow_q <= 1'b0;
    end else begin
      r_bin_q       <= r_bin_d;
      r_gray_q      <= r_gray_d;
      r_empty_q     <= r_empty_d;
      r_ae_q        <= r_ae_d;
      r_count_q     <= r_count_d;
      r_underflow_q <= r_underflow_d;
    end
  end

  assign gr_r_ptr             = r_gray_q;
  assign rd_if.r_addr         = r_bin_q[ADDR_WIDTH-1:0];
  assign rd_if.r_empty        = r_empty_q;
  assign rd_if.r_almost_empty = r_ae_q;
  assign rd_if.r_count        = r_count_q;
  assign rd_if.r_underflow    = r_underflow_q;

endmodule

// File: tb/tb_r_empty_ctrl.sv
// Bench for r_empty_ctrl (ADDR_WIDTH=3, AE_THRESH=1): vector tables plus a wrap-around
// sequence, expectations queued at drive time and compared after the following edge.
module tb_r_empty_ctrl;

  localparam int AW = 3;

  logic          r_clk = 1'b0;
  logic          r_rst;
  logic [AW:0]   unsync_w_ptr;
  logic [AW:0]   gr_r_ptr;

  r_empty_ctrl_if #(.ADDR_WIDTH(AW)) rd_if ();

  r_empty_ctrl #(.ADDR_WIDTH(AW), .AE_THRESH(1)) dut (
    .r_clk        (r_clk),
    .r_rst        (r_rst),
    .unsync_w_ptr (unsync_w_ptr),
    .gr_r_ptr     (gr_r_ptr),
    .rd_if        (rd_if)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       inc;
    logic [3:0] w;
    logic       empty;
    logic       ae;
    logic [3:0] count;
    logic [2:0] addr;
    logic [3:0] gptr;
    logic       uf;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_g[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input string name, input logic rst, input logic inc,
                              input logic [3:0] w, input logic empty, input logic ae,
                              input logic [3:0] count, input logic [2:0] addr,
                              input logic [3:0] gptr, input logic uf);
    vec_t v;
    v.name = name; v.rst = rst; v.inc = inc; v.w = w;
    v.empty = empty; v.ae = ae; v.count = count; v.addr = addr; v.gptr = gptr; v.uf = uf;
    return v;
  endfunction

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input vec_t v);
    vec_t e;
    r_rst        = v.rst;
    rd_if.r_inc  = v.inc;
    unsync_w_ptr = v.w;
    exp_q.push_back(v);
    @(posedge r_clk);
    @(negedge r_clk);
    e = exp_q.pop_front();
    check({e.name, ".empty"}, 32'(rd_if.r_empty),        32'(e.empty));
    check({e.name, ".ae"},    32'(rd_if.r_almost_empty), 32'(e.ae));
    check({e.name, ".count"}, 32'(rd_if.r_count),        32'(e.count));
    check({e.name, ".addr"},  32'(rd_if.r_addr),         32'(e.addr));
    check({e.name, ".gptr"},  32'(gr_r_ptr),             32'(e.gptr));
    check({e.name, ".uf"},    32'(rd_if.r_underflow),    32'(e.uf));
  endtask

  initial begin
    r_rst        = 1'b1;
    rd_if.r_inc  = 1'b0;
    unsync_w_ptr = '0;

    //                 name      rst  inc  w        emp  ae   cnt  addr  gptr     uf
    // Reset dominates a pending read and a nonzero write pointer.
    tab_a.push_back(mk("rst0",   1,   1,   4'b0110, 1,   1,   0,   0,    4'b0000, 0));
    tab_a.push_back(mk("rst1",   1,   1,   4'b0110, 1,   1,   0,   0,    4'b0000, 0));
    tab_a.push_back(mk("rst2",   1,   1,   4'b0110, 1,   1,   0,   0,    4'b0000, 0));
    // Write pointer 0 -> 1 shows up on the third edge.
    tab_a.push_back(mk("lat1",   0,   0,   4'b0001, 1,   1,   0,   0,    4'b0000, 0));
    tab_a.push_back(mk("lat2",   0,   0,   4'b0001, 1,   1,   0,   0,    4'b0000, 0));
    tab_a.push_back(mk("lat3",   0,   0,   4'b0001, 0,   1,   1,   0,    4'b0000, 0));
    // Write pointer to binary 5 (gray 0111), then five back-to-back reads.
    tab_a.push_back(mk("set5a",  0,   0,   4'b0111, 0,   1,   1,   0,    4'b0000, 0));
    tab_a.push_back(mk("set5b",  0,   0,   4'b0111, 0,   1,   1,   0,    4'b0000, 0));
    tab_a.push_back(mk("set5c",  0,   0,   4'b0111, 0,   0,   5,   0,    4'b0000, 0));
    tab_a.push_back(mk("rd1",    0,   1,   4'b0111, 0,   0,   4,   1,    4'b0001, 0));
    tab_a.push_back(mk("rd2",    0,   1,   4'b0111, 0,   0,   3,   2,    4'b0011, 0));
    tab_a.push_back(mk("rd3",    0,   1,   4'b0111, 0,   0,   2,   3,    4'b0010, 0));
    tab_a.push_back(mk("rd4",    0,   1,   4'b0111, 0,   1,   1,   4,    4'b0110, 0));
    tab_a.push_back(mk("rd5",    0,   1,   4'b0111, 1,   1,   0,   5,    4'b0111, 0));
    // Read while empty: one-cycle underflow, pointers frozen.
    tab_a.push_back(mk("uf1",    0,   1,   4'b0111, 1,   1,   0,   5,    4'b0111, 1));
    tab_a.push_back(mk("uf2",    0,   0,   4'b0111, 1,   1,   0,   5,    4'b0111, 0));
    // Full: read pointer 0, write pointer binary 8 (gray 1100).
    tab_a.push_back(mk("full0",  1,   0,   4'b1100, 1,   1,   0,   0,    4'b0000, 0));
    tab_a.push_back(mk("full1",  0,   0,   4'b1100, 1,   1,   0,   0,    4'b0000, 0));
    tab_a.push_back(mk("full2",  0,   0,   4'b1100, 1,   1,   0,   0,    4'b0000, 0));
    tab_a.push_back(mk("full3",  0,   0,   4'b1100, 0,   0,   8,   0,    4'b0000, 0));

    // Reset asserted mid-drain after the wrap sequence.
    tab_g.push_back(mk("mid0",   0,   0,   4'b0010, 1,   1,   0,   0,    4'b0000, 0));
    tab_g.push_back(mk("mid1",   0,   0,   4'b0010, 1,   1,   0,   0,    4'b0000, 0));
    tab_g.push_back(mk("mid2",   0,   0,   4'b0010, 0,   0,   3,   0,    4'b0000, 0));
    tab_g.push_back(mk("mid3",   0,   1,   4'b0010, 0,   0,   2,   1,    4'b0001, 0));
    tab_g.push_back(mk("mid4",   1,   1,   4'b0010, 1,   1,   0,   0,    4'b0000, 0));
    tab_g.push_back(mk("mid5",   0,   0,   4'b0010, 1,   1,   0,   0,    4'b0000, 0));

    foreach (tab_a[i]) step(tab_a[i]);

    // Wrap: drain the 8 entries, move the write pointer to binary 16 (gray 0000),
    // then drain 8 more so the read pointer MSB toggles back to 0.
    for (int i = 1; i <= 8; i++) begin
      step(mk($sformatf("wrap_a%0d", i), 0, 1, 4'b1100, (i == 8), ((8 - i) <= 1),
              4'(8 - i), 3'(i % 8), gray4(4'(i)), 0));
    end
    step(mk("wrap_w1", 0, 0, 4'b0000, 1, 1, 0, 0, 4'b1100, 0));
    step(mk("wrap_w2", 0, 0, 4'b0000, 1, 1, 0, 0, 4'b1100, 0));
    step(mk("wrap_w3", 0, 0, 4'b0000, 0, 0, 8, 0, 4'b1100, 0));
    for (int i = 9; i <= 16; i++) begin
      step(mk($sformatf("wrap_b%0d", i), 0, 1, 4'b0000, (i == 16), ((16 - i) <= 1),
              4'(16 - i), 3'(i % 8), gray4(4'(i)), 0));
    end

    foreach (tab_g[i]) step(tab_g[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
